scene_recovery: RTL and testbench

Scene-radiance recovery stage of the dehazing pipeline, directly downstream of the transmission estimator. It buffers each raw 24-bit pixel while the estimator works on it. When the matching 8-bit transmission arrives, it computes the dehazed pixel per channel as J = (I − A)·255/max(t, T0) + A and emits it in stream order.

---
 rtl/scene_recovery.sv | 130 +++++++++++++
 tb/tb_scene_recovery.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/scene_recovery.sv
// rtl/scene_recovery.sv - scene-radiance recovery: pixel buffer plus J = (I - A)*255/max(t,T0) + A pipeline
module scene_recovery #(
  parameter int FIFO_DEPTH = 2048,
  parameter int T0         = 26,
  parameter int FRAC       = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] input_pixel,
  input  logic        input_is_valid,
  input  logic [7:0]  transmission,
  input  logic        trans_valid,
  input  logic [23:0] atm_light,
  output logic [23:0] output_pixel,
  output logic        output_valid,
  output logic        overflow,
  output logic        underflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // Reciprocal table packed 16 bits per entry; entries below the floor are unreachable.
  function automatic logic [16*256-1:0] build_rom();
    logic [16*256-1:0] r;
    r = '0;
    for (int i = T0; i < 256; i++) r[i*16 +: 16] = 16'((255 * (1 << FRAC)) / i);
    return r;
  endfunction
  localparam logic [16*256-1:0] RECIP_ROM = build_rom();

  logic [23:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic          overflow_q, underflow_q;

  logic        v0_q, v1_q, v2_q, v3_q, out_valid_q;
  logic [23:0] pix0_q, pix1_q, a2_q, a3_q, out_pixel_q;
  logic [7:0]  t0_q, tp1_q;
  logic [15:0] recip2_q;
  logic signed [8:0]  diff2_q [3];
  logic signed [25:0] prod3_q [3];
  logic [23:0] sat_d;

  // A pop at full frees the slot for a same-cycle push; no write-to-read bypass at empty.
  always_comb begin
    pop     = trans_valid && (count_q != '0);
    push    = input_is_valid && ((count_q != CW'(FIFO_DEPTH)) || pop);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= input_pixel;
  end

  always_comb begin
    logic signed [25:0] sh;
    logic signed [14:0] sum;
    sat_d = '0;
    for (int c = 0; c < 3; c++) begin
      sh  = prod3_q[c] >>> FRAC;
      sum = $signed(sh[14:0]) + $signed({7'b0, a3_q[c*8 +: 8]});
      if (sum < 0)        sat_d[c*8 +: 8] = 8'd0;
      else if (sum > 255) sat_d[c*8 +: 8] = 8'd255;
      else                sat_d[c*8 +: 8] = sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      pix0_q      <= '0;
      pix1_q      <= '0;
      t0_q        <= '0;
      tp1_q       <= '0;
      recip2_q    <= '0;
      a2_q        <= '0;
      a3_q        <= '0;
      for (int c = 0; c < 3; c++) begin
        diff2_q[c] <= '0;
        prod3_q[c] <= '0;
      end
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      overflow_q  <= overflow_q  | (input_is_valid && !push);
      underflow_q <= underflow_q | (trans_valid && (count_q == '0));

      v0_q <= pop;
      if (pop) begin
        pix0_q <= mem_q[rd_ptr_q];
        t0_q   <= transmission;
      end

      v1_q   <= v0_q;
      pix1_q <= pix0_q;
      tp1_q  <= (t0_q < 8'(T0)) ? 8'(T0) : t0_q;

      v2_q     <= v1_q;
      recip2_q <= RECIP_ROM[{tp1_q, 4'b0000} +: 16];
      a2_q     <= atm_light;
      for (int c = 0; c < 3; c++)
        diff2_q[c] <= $signed({1'b0, pix1_q[c*8 +: 8]}) - $signed({1'b0, atm_light[c*8 +: 8]});

      v3_q <= v2_q;
      a3_q <= a2_q;
      for (int c = 0; c < 3; c++)
        prod3_q[c] <= diff2_q[c] * $signed({1'b0, recip2_q});

      out_valid_q <= v3_q;
      if (v3_q) out_pixel_q <= sat_d;
    end
  end

  assign output_pixel = out_pixel_q;
  assign output_valid = out_valid_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;
endmodule

// File: tb/tb_scene_recovery.sv
// tb/tb_scene_recovery.sv - directed vector table plus multi-cycle corner sequences for scene_recovery
module tb_scene_recovery;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] input_pixel = '0;
  logic        input_is_valid = 1'b0;
  logic [7:0]  transmission = '0;
  logic        trans_valid = 1'b0;
  logic [23:0] atm_light = '0;
  logic [23:0] output_pixel;
  logic        output_valid;
  logic        overflow;
  logic        underflow;

  scene_recovery dut (
    .clk(clk), .rst(rst),
    .input_pixel(input_pixel), .input_is_valid(input_is_valid),
    .transmission(transmission), .trans_valid(trans_valid),
    .atm_light(atm_light),
    .output_pixel(output_pixel), .output_valid(output_valid),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [23:0] out_q[$];
  int          ocyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && output_valid) begin
    out_q.push_back(output_pixel);
    ocyc_q.push_back(cyc);
  end

  typedef struct {
    logic [23:0] pix;
    logic [23:0] atm;
    logic [7:0]  t;
    logic [23:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [23:0] p);
    input_pixel    = p;
    input_is_valid = 1'b1;
    step();
    input_is_valid = 1'b0;
  endtask

  task automatic pop(input logic [7:0] t, output int n);
    transmission = t;
    trans_valid  = 1'b1;
    n = cyc + 1;
    step();
    trans_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_q.delete();
    ocyc_q.delete();
  endtask

  vec_t vecs[7];
  int   n;
  int   tv[8];
  logic [23:0] p8[8];

  initial begin
    vecs[0] = '{pix: 24'h6496FA, atm: 24'hC8C8C8, t: 8'd255, exp: 24'h6496FA};
    vecs[1] = '{pix: 24'hD2C7C8, atm: 24'hC8C8C8, t: 8'd10,  exp: 24'hFFBEC8};
    vecs[2] = '{pix: 24'h64DCC8, atm: 24'hC8C8C8, t: 8'd128, exp: 24'h00EFC8};
    vecs[3] = '{pix: 24'h0A141E, atm: 24'h000000, t: 8'd255, exp: 24'h0A141E};
    vecs[4] = '{pix: 24'h321E28, atm: 24'h282828, t: 8'd64,  exp: 24'h4F0028};
    vecs[5] = '{pix: 24'h010007, atm: 24'h000000, t: 8'd26,  exp: 24'h090044};
    vecs[6] = '{pix: 24'h010007, atm: 24'h000000, t: 8'd25,  exp: 24'h090044};

    step();
    step();
    check("reset_output_pixel", {8'd0, output_pixel}, 32'd0);
    check("reset_output_valid", {31'd0, output_valid}, 32'd0);
    check("reset_flags", {30'd0, overflow, underflow}, 32'd0);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      out_q.delete();
      ocyc_q.delete();
      atm_light = vecs[i].atm;
      push(vecs[i].pix);
      pop(vecs[i].t, n);
      repeat (8) step();
      check($sformatf("vec%0d_count", i), out_q.size(), 1);
      if (out_q.size() > 0) begin
        check($sformatf("vec%0d_pixel", i), {8'd0, out_q[0]}, {8'd0, vecs[i].exp});
        check($sformatf("vec%0d_latency", i), ocyc_q[0], n + 4);
      end
    end

    // ordering: 8 back-to-back pushes, delayed pops with gaps, identity transform
    do_reset();
    atm_light = 24'hC8C8C8;
    for (int i = 0; i < 8; i++) begin
      p8[i] = 24'h101010 * 24'(i + 1) + 24'h030201;
      push(p8[i]);
    end
    repeat (20) step();
    for (int i = 0; i < 8; i++) begin
      pop(8'd255, tv[i]);
      repeat (i % 3) step();
    end
    repeat (10) step();
    check("order_count", out_q.size(), 8);
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      check($sformatf("order%0d_pixel", i), {8'd0, out_q[i]}, {8'd0, p8[i]});
      check($sformatf("order%0d_latency", i), ocyc_q[i], tv[i] + 4);
    end
    check("order_flags", {30'd0, overflow, underflow}, 32'd0);

    // underflow on empty buffer
    do_reset();
    pop(8'd255, n);
    check("underflow_set", {31'd0, underflow}, 32'd1);
    repeat (8) step();
    check("underflow_no_output", out_q.size(), 0);
    check("underflow_no_overflow", {31'd0, overflow}, 32'd0);

    // fill to full, push+pop at full, then overflow
    do_reset();
    atm_light = 24'h000000;
    for (int i = 0; i < 2048; i++) push(24'(i * 7919 + 1));
    check("full_count", dut.count_q, 2048);
    check("full_no_overflow", {31'd0, overflow}, 32'd0);
    input_pixel    = 24'hABCDEF;
    input_is_valid = 1'b1;
    pop(8'd255, n);
    input_is_valid = 1'b0;
    check("pushpop_full_no_overflow", {31'd0, overflow}, 32'd0);
    check("pushpop_full_count", dut.count_q, 2048);
    push(24'h123456);
    check("overflow_set", {31'd0, overflow}, 32'd1);
    check("overflow_count", dut.count_q, 2048);
    pop(8'd255, n);
    repeat (8) step();
    check("overflow_out_count", out_q.size(), 2);
    if (out_q.size() >= 2) begin
      check("first_in_intact", {8'd0, out_q[0]}, 32'd1);
      check("second_in_intact", {8'd0, out_q[1]}, 32'd7920);
    end

    // reset mid-stream: underflow flagged, 5 buffered, 2 in pipeline
    do_reset();
    pop(8'd255, n);
    for (int i = 0; i < 7; i++) push(24'h500000 + 24'(i));
    pop(8'd255, n);
    pop(8'd255, n);
    rst = 1'b1;
    step();
    check("midrst_output_pixel", {8'd0, output_pixel}, 32'd0);
    check("midrst_output_valid", {31'd0, output_valid}, 32'd0);
    check("midrst_flags", {30'd0, overflow, underflow}, 32'd0);
    rst = 1'b0;
    out_q.delete();
    ocyc_q.delete();
    repeat (8) step();
    check("midrst_flushed", out_q.size(), 0);
    atm_light = 24'hC8C8C8;
    push(24'hD2C7C8);
    pop(8'd10, n);
    repeat (8) step();
    check("midrst_fresh_count", out_q.size(), 1);
    if (out_q.size() > 0) begin
      check("midrst_fresh_pixel", {8'd0, out_q[0]}, 32'hFFBEC8);
      check("midrst_fresh_latency", ocyc_q[0], n + 4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
